vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator. It replaces the fixed hsync/vsync counter pair.
//  From one system clock it derives a pixel-enable strobe and runs the h/v counters.
//  Outputs: sync pulses with selectable polarity, pixel coordinates, an active-video flag
//  and frame/line start strobes. Sits between the board clock and the image generator.
//  A configurable pixel-cycle delay aligns sync/active with a pipelined colour path.
// PARAMETERS
//  CLK_DIV   2    system clocks per pixel (>=1); 2 gives 25 MHz from CLOCK_50
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync pulse width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync pulse width, lines
//  V_BP      33   vertical back porch, lines
//  HS_POL    0    hsync asserted level (0 = active low)
//  VS_POL    0    vsync asserted level (0 = active low)
//  PIPE_DLY  0    pixel cycles of extra delay on o_hsync/o_vsync/o_active (0..7)
//  CW        12   width of coordinate outputs
// PORTS
//  CLOCK_50       in   1   system clock
//  i_rst          in   1   synchronous reset, active high
//  i_en           in   1   run enable; low freezes all counters and outputs
//  o_pix_en       out  1   one-clock strobe, once per pixel period
//  o_x            out  CW  horizontal counter 0..H_TOTAL-1 (undelayed)
//  o_y            out  CW  vertical counter 0..V_TOTAL-1 (undelayed)
//  o_active       out  1   visible-region flag, delayed PIPE_DLY pixels
//  o_hsync        out  1   horizontal sync, delayed PIPE_DLY pixels
//  o_vsync        out  1   vertical sync, delayed PIPE_DLY pixels
//  o_line_start   out  1   one-clock strobe with o_pix_en when o_x becomes 0
//  o_frame_start  out  1   one-clock strobe with o_pix_en when o_x and o_y both become 0
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults give 800 x 525.
//  - Reset values: div, h, v counters = 0; o_x = o_y = 0; o_pix_en = o_active = 0.
//    o_hsync = ~HS_POL, o_vsync = ~VS_POL; strobes = 0; delay pipeline cleared to inactive.
//  - Divider: div counts 0..CLK_DIV-1 while i_en.
//    o_pix_en is registered high for the one clock after div reaches CLK_DIV-1.
//    CLK_DIV = 1 gives o_pix_en constantly high.
//  - Counter advance happens only on a clock with the pix_en strobe.
//    h increments and wraps H_TOTAL-1 -> 0. When h wraps, v increments and wraps V_TOTAL-1 -> 0.
//    h and v update in the same clock.
//  - o_x/o_y are registered copies of h/v and update in the same clock as o_pix_en.
//  - Decode, from the new h/v value:
//    - hs_raw asserted when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
//    - vs_raw asserted when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
//    - act_raw asserted when h < H_ACTIVE && v < V_ACTIVE.
//  - Delay pipeline:
//    - PIPE_DLY = 0: raw decodes are registered directly to the outputs, aligned with o_x/o_y.
//    - PIPE_DLY = N: a shift register advances only on pix_en, so outputs lag o_x/o_y
//      by exactly N pixel periods.
//  - Strobes: o_line_start when new h == 0; o_frame_start when new h == 0 && v == 0.
//    Both are high only in pix_en clocks and are never delayed.
//  - i_en low: div, counters, pipeline and all outputs hold; o_pix_en and strobes forced 0.
//    Resume continues from the held point with no skipped or doubled pixel.
//  - i_rst wins over i_en. Reset mid-frame restarts at h = v = 0 on the next clock.
//    The first o_frame_start then follows H_TOTAL*V_TOTAL pixel periods later.
//  - Widths: CW must satisfy 2^CW > max(H_TOTAL, V_TOTAL). Counter compares are unsigned.
// TESTING
//  1. Defaults, i_en = 1: clocks between consecutive o_frame_start = 800*525*2 = 840000.
//     Exactly 640*480 = 307200 o_pix_en clocks with o_active = 1 per frame.
//  2. Defaults: o_hsync low for exactly 96 pixels (192 clocks), first low at o_x = 656.
//     o_vsync low for lines 490..491 only.
//  3. Small mode (CLK_DIV=1, H 4/1/2/1, V 3/1/1/1, HS_POL=VS_POL=1): H_TOTAL = 8, frame = 48 clocks.
//     o_hsync high at o_x = 5,6. o_frame_start every 48 clocks.
//  4. PIPE_DLY = 3, defaults: o_active rises 3 pixels (6 clocks) after o_x = 0 on line 0.
//     o_hsync falls when o_x = 659.
//  5. Assert i_rst at o_x = 300, o_y = 200 for 1 clock: next clock o_x = o_y = 0 and o_hsync = 1.
//     o_frame_start next occurs after 840000 clocks.
//  6. Drop i_en for 37 clocks at o_x = 100: outputs frozen, no o_pix_en.
//     After release o_x = 101 on the next pix_en. Frame period grows by exactly 37 clocks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, h/v counters, sync/active decode, strobes.
// Latency: o_x/o_y/strobes register the new count on the pix_en clock; sync/active lag a further PIPE_DLY pixels.
// Backpressure: none; i_en low freezes every counter and output (pix_en and strobes forced low).
module vga_timing_gen #(
   parameter int   CLK_DIV  = 2,
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   PIPE_DLY = 0,
   parameter int   CW       = 12
) (
   input  logic          CLOCK_50,
   input  logic          i_rst,
   input  logic          i_en,
   output logic          o_pix_en,
   output logic [CW-1:0] o_x,
   output logic [CW-1:0] o_y,
   output logic          o_active,
   output logic          o_hsync,
   output logic          o_vsync,
   output logic          o_line_start,
   output logic          o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] h_q, h_d;
   logic [CW-1:0] v_q, v_d;
   logic          pix_en_q, pix_en_d;
   logic          act_q, act_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          ls_q, ls_d;
   logic          fs_q, fs_d;
   logic          tick;

   // raw_vec / dly_vec bit order: {active, hsync asserted, vsync asserted}
   logic [2:0]    raw_vec;
   logic [2:0]    dly_vec;

   // Divider and raster counters; h/v advance together on the tick clock
   always_comb begin
      tick  = i_en && (div_q == DIV_LAST);
      div_d = div_q;
      h_d   = h_q;
      v_d   = v_q;
      if (i_en) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end
      if (tick) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   // Region decode from the count being loaded this clock
   always_comb begin
      raw_vec    = 3'b000;
      raw_vec[2] = (h_d < H_ACT) && (v_d < V_ACT);
      raw_vec[1] = (h_d >= HS_BEG) && (h_d < HS_END);
      raw_vec[0] = (v_d >= VS_BEG) && (v_d < VS_END);
   end

   generate
      if (PIPE_DLY == 0) begin : g_nodly
         // No alignment delay: decode goes straight to the output registers
         always_comb begin
            dly_vec = raw_vec;
         end
      end else begin : g_dly
         logic [2:0] pipe_q [PIPE_DLY];
         logic [2:0] pipe_d [PIPE_DLY];

         // Shift the decodes one stage per pixel so outputs trail o_x/o_y by PIPE_DLY pixels
         always_comb begin
            for (int i = 0; i < PIPE_DLY; i++) begin
               pipe_d[i] = pipe_q[i];
            end
            if (tick) begin
               pipe_d[0] = raw_vec;
               for (int i = 1; i < PIPE_DLY; i++) begin
                  pipe_d[i] = pipe_q[i-1];
               end
            end
         end

         // Delay stages start out as "inactive, no sync"
         always_ff @(posedge CLOCK_50) begin
            if (i_rst) begin
               for (int i = 0; i < PIPE_DLY; i++) begin
                  pipe_q[i] <= 3'b000;
               end
            end else begin
               for (int i = 0; i < PIPE_DLY; i++) begin
                  pipe_q[i] <= pipe_d[i];
               end
            end
         end

         assign dly_vec = pipe_q[PIPE_DLY-1];
      end
   endgenerate

   // Output stage: strobes only on tick clocks, levels only change on tick clocks
   always_comb begin
      pix_en_d = tick;
      ls_d     = tick && (h_d == '0);
      fs_d     = tick && (h_d == '0) && (v_d == '0);
      act_d    = act_q;
      hs_d     = hs_q;
      vs_d     = vs_q;
      if (tick) begin
         act_d = dly_vec[2];
         hs_d  = dly_vec[1] ? HS_POL : ~HS_POL;
         vs_d  = dly_vec[0] ? VS_POL : ~VS_POL;
      end
   end

   // State registers; reset parks syncs at their inactive level
   always_ff @(posedge CLOCK_50) begin
      if (i_rst) begin
         div_q    <= '0;
         h_q      <= '0;
         v_q      <= '0;
         pix_en_q <= 1'b0;
         act_q    <= 1'b0;
         hs_q     <= ~HS_POL;
         vs_q     <= ~VS_POL;
         ls_q     <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         div_q    <= div_d;
         h_q      <= h_d;
         v_q      <= v_d;
         pix_en_q <= pix_en_d;
         act_q    <= act_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         ls_q     <= ls_d;
         fs_q     <= fs_d;
      end
   end

   assign o_pix_en      = pix_en_q;
   assign o_x           = h_q;
   assign o_y           = v_q;
   assign o_active      = act_q;
   assign o_hsync       = hs_q;
   assign o_vsync       = vs_q;
   assign o_line_start  = ls_q;
   assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised enable/reset stimulus into two configurations, checked against a pixel-count model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic en;

   // Configuration A: divided clock, mixed polarity, 2-pixel delay
   logic       a_pix_en, a_act, a_hs, a_vs, a_ls, a_fs;
   logic [5:0] a_x, a_y;
   // Configuration B: small mode, undivided, both syncs active high
   logic       b_pix_en, b_act, b_hs, b_vs, b_ls, b_fs;
   logic [3:0] b_x, b_y;

   vga_timing_gen #(
      .CLK_DIV(3), .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_DLY(2), .CW(6)
   ) u_dut_a (
      .CLOCK_50(clk), .i_rst(rst), .i_en(en),
      .o_pix_en(a_pix_en), .o_x(a_x), .o_y(a_y), .o_active(a_act),
      .o_hsync(a_hs), .o_vsync(a_vs), .o_line_start(a_ls), .o_frame_start(a_fs)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0), .CW(4)
   ) u_dut_b (
      .CLOCK_50(clk), .i_rst(rst), .i_en(en),
      .o_pix_en(b_pix_en), .o_x(b_x), .o_y(b_y), .o_active(b_act),
      .o_hsync(b_hs), .o_vsync(b_vs), .o_line_start(b_ls), .o_frame_start(b_fs)
   );

   // Model configuration, mirrors the parameter overrides above
   int DIV [2], HA [2], HF [2], HSW [2], HB [2];
   int VA [2], VF [2], VSW [2], VB [2], HP [2], VP [2], DLY [2];

   // Model state: enabled clocks since reset, pixels since reset, tick this clock
   int ec [2];
   int pc [2];
   int tk [2];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
   endtask

   task automatic model_step(input int k);
      if (rst) begin
         ec[k] = 0;
         pc[k] = 0;
         tk[k] = 0;
      end else if (en) begin
         tk[k] = ((ec[k] % DIV[k]) == DIV[k] - 1) ? 1 : 0;
         ec[k]++;
         if (tk[k] != 0) pc[k]++;
      end else begin
         tk[k] = 0;
      end
   endtask

   task automatic check_inst(input int k, input int pe, input int x, input int y,
                             input int act, input int hs, input int vs,
                             input int ls, input int fs);
      int    ht, vt, ex, ey, q, qx, qy;
      int    e_act, e_hs, e_vs;
      string n;
      n  = (k == 0) ? "A" : "B";
      ht = HA[k] + HF[k] + HSW[k] + HB[k];
      vt = VA[k] + VF[k] + VSW[k] + VB[k];
      ex = pc[k] % ht;
      ey = (pc[k] / ht) % vt;
      e_act = 0;
      e_hs  = 0;
      e_vs  = 0;
      if (pc[k] > DLY[k]) begin
         q  = pc[k] - DLY[k];
         qx = q % ht;
         qy = (q / ht) % vt;
         e_act = (qx < HA[k] && qy < VA[k]) ? 1 : 0;
         e_hs  = (qx >= HA[k] + HF[k] && qx < HA[k] + HF[k] + HSW[k]) ? 1 : 0;
         e_vs  = (qy >= VA[k] + VF[k] && qy < VA[k] + VF[k] + VSW[k]) ? 1 : 0;
      end
      chk({n, ".pix_en"}, pe, tk[k]);
      chk({n, ".x"}, x, ex);
      chk({n, ".y"}, y, ey);
      chk({n, ".active"}, act, e_act);
      chk({n, ".hsync"}, hs, (e_hs != 0) ? HP[k] : 1 - HP[k]);
      chk({n, ".vsync"}, vs, (e_vs != 0) ? VP[k] : 1 - VP[k]);
      chk({n, ".line_start"}, ls, (tk[k] != 0 && ex == 0) ? 1 : 0);
      chk({n, ".frame_start"}, fs, (tk[k] != 0 && ex == 0 && ey == 0) ? 1 : 0);
   endtask

   initial begin
      DIV = '{3, 1};
      HA  = '{6, 4};  HF = '{2, 1};  HSW = '{3, 2};  HB = '{2, 1};
      VA  = '{4, 3};  VF = '{1, 1};  VSW = '{2, 1};  VB = '{1, 1};
      HP  = '{0, 1};  VP = '{1, 1};  DLY = '{2, 0};
      ec  = '{0, 0};  pc = '{0, 0};  tk  = '{0, 0};
      rst = 1'b1;
      en  = 1'b0;

      for (int c = 0; c < 8000; c++) begin
         @(negedge clk);
         // Long free-running stretch first so whole frames pass, then random freezes and resets
         rst = (c < 3) || ($urandom_range(0, 599) == 0);
         en  = (c < 1200) ? 1'b1 : ($urandom_range(0, 4) != 0);
         if (c >= 4000 && c < 4400) en = ($urandom_range(0, 1) == 0);
         @(posedge clk);
         model_step(0);
         model_step(1);
         #1;
         check_inst(0, int'(a_pix_en), int'(a_x), int'(a_y), int'(a_act),
                    int'(a_hs), int'(a_vs), int'(a_ls), int'(a_fs));
         check_inst(1, int'(b_pix_en), int'(b_x), int'(b_y), int'(b_act),
                    int'(b_hs), int'(b_vs), int'(b_ls), int'(b_fs));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
